mem_rr_arbiter: RTL and testbench

- N-port round-robin arbiter in front of the single physical memory port. Shared by the DMA engine and the compute cores.
- Supports up to DEPTH outstanding reads. Memory returns read data in order; a tag FIFO of granted port indices routes each response to its requester.
- Replaces the one-read-in-flight fixed-priority scheme, so the cores can pipeline loads without starving one another.

---
 rtl/mem_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// N-port round-robin arbiter for a single memory port with in-order read tag routing.
// Optional MEM_ARB_DMA_PRIO_EN: port 0 becomes fixed highest priority, ports 1..N-1 rotate.
module mem_rr_arbiter #(
  parameter int NPORTS = 3,
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NPORTS-1:0]          req,
  input  logic [NPORTS-1:0]          we,
  input  logic [NPORTS*AW-1:0]       addr,
  input  logic [NPORTS*DW-1:0]       wdata,
  output logic [NPORTS-1:0]          gnt,
  output logic [NPORTS-1:0]          valid,
  output logic [DW-1:0]              rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_valid,
  input  logic [DW-1:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err_unexp
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int FW = $clog2(DEPTH);
  localparam int CW = FW + 1;

`ifdef MEM_ARB_DMA_PRIO_EN
  localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
  localparam logic [PW-1:0] PTR_RST = PW'(0);
`endif

  logic [AW-1:0]     addr_a_s  [NPORTS];
  logic [DW-1:0]     wdata_a_s [NPORTS];
  logic [NPORTS-1:0] elig_s;
  logic [NPORTS-1:0] gnt_nxt_s;
  logic [NPORTS-1:0] valid_nxt_s;
  logic              room_s;
  logic              pop_s;
  logic              push_s;
  logic              unexp_s;
  logic              win_found_s;
  logic [PW-1:0]     win_s;
  logic [PW-1:0]     ptr_nxt_s;
  logic [PW-1:0]     head_s;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     tag_r [DEPTH];
  logic [FW-1:0]     wr_ptr_r;
  logic [FW-1:0]     rd_ptr_r;

  // A pop in the same cycle frees a slot for a new read.
  assign pop_s   = mem_valid & (outstanding != CW'(0));
  assign unexp_s = mem_valid & (outstanding == CW'(0));
  assign room_s  = (outstanding < CW'(DEPTH)) | pop_s;
  assign head_s  = tag_r[rd_ptr_r];
  assign push_s  = win_found_s & ~we[win_s];

  // Unpack flattened port buses and form per-port eligibility and one-hot pulses.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      addr_a_s[i]    = addr[i*AW +: AW];
      wdata_a_s[i]   = wdata[i*DW +: DW];
      elig_s[i]      = req[i] & ~gnt[i] & (we[i] | room_s);
      gnt_nxt_s[i]   = win_found_s & (win_s == PW'(i));
      valid_nxt_s[i] = pop_s & (head_s == PW'(i));
    end
  end

  // Winner selection: scan downwards so the port closest to ptr wins last.
  always_comb begin : arb_comb
    int idx;
    idx         = 0;
    win_found_s = 1'b0;
    win_s       = PW'(0);
`ifdef MEM_ARB_DMA_PRIO_EN
    for (int k = NPORTS - 2; k >= 0; k--) begin
      idx         = int'(ptr_r) + k;
      idx         = (idx > NPORTS - 1) ? idx - (NPORTS - 1) : idx;
      win_found_s = elig_s[PW'(idx)] ? 1'b1 : win_found_s;
      win_s       = elig_s[PW'(idx)] ? PW'(idx) : win_s;
    end
    win_found_s = elig_s[0] ? 1'b1 : win_found_s;
    win_s       = elig_s[0] ? PW'(0) : win_s;
    if (win_found_s && (win_s != PW'(0))) begin
      ptr_nxt_s = (win_s == PW'(NPORTS - 1)) ? PW'(1) : win_s + PW'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
`else
    for (int k = NPORTS - 1; k >= 0; k--) begin
      idx         = int'(ptr_r) + k;
      idx         = (idx >= NPORTS) ? idx - NPORTS : idx;
      win_found_s = elig_s[PW'(idx)] ? 1'b1 : win_found_s;
      win_s       = elig_s[PW'(idx)] ? PW'(idx) : win_s;
    end
    if (win_found_s) begin
      ptr_nxt_s = (win_s == PW'(NPORTS - 1)) ? PW'(0) : win_s + PW'(1);
    end else begin
      ptr_nxt_s = ptr_r;
    end
`endif
  end

  // Grant pulse, memory command register and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= {NPORTS{1'b0}};
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
      ptr_r     <= PTR_RST;
    end else begin
      gnt     <= gnt_nxt_s;
      mem_req <= win_found_s;
      ptr_r   <= ptr_nxt_s;
      if (win_found_s) begin
        mem_we    <= we[win_s];
        mem_addr  <= addr_a_s[win_s];
        mem_wdata <= wdata_a_s[win_s];
      end
    end
  end

  // Tag FIFO of granted read ports; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= FW'(0);
      rd_ptr_r    <= FW'(0);
      outstanding <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i] <= PW'(0);
      end
    end else begin
      if (push_s) begin
        tag_r[wr_ptr_r] <= win_s;
        wr_ptr_r        <= wr_ptr_r + FW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + FW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response routing and the sticky unexpected-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= {NPORTS{1'b0}};
      rdata     <= {DW{1'b0}};
      err_unexp <= 1'b0;
    end else begin
      valid     <= valid_nxt_s;
      err_unexp <= err_unexp | unexp_s;
      if (pop_s) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model (honours MEM_ARB_DMA_PRIO_EN).
module tb_mem_rr_arbiter;

  localparam int NPORTS = 3;
  localparam int AW     = 64;
  localparam int DW     = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int OW     = 2*NPORTS + 2*DW + AW + 2 + CW + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [NPORTS-1:0]      req = '0;
  logic [NPORTS-1:0]      we = '0;
  logic [NPORTS*AW-1:0]   addr = '0;
  logic [NPORTS*DW-1:0]   wdata = '0;
  logic                   mem_valid = 1'b0;
  logic [DW-1:0]          mem_rdata = '0;
  logic [NPORTS-1:0]      gnt;
  logic [NPORTS-1:0]      valid;
  logic [DW-1:0]          rdata;
  logic                   mem_req;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic [CW-1:0]          outstanding;
  logic                   err_unexp;

  mem_rr_arbiter #(.NPORTS(NPORTS), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .valid(valid), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .outstanding(outstanding), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  wire [OW-1:0] obs = {gnt, valid, rdata, mem_req, mem_we, mem_addr, mem_wdata, outstanding, err_unexp};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int                m_ptr;
  int                q[$];
  logic [NPORTS-1:0] e_gnt, e_valid;
  logic [DW-1:0]     e_rdata;
  logic              e_mem_req, e_mem_we, e_err;
  logic [AW-1:0]     e_mem_addr;
  logic [DW-1:0]     e_mem_wdata;
  int                got_order[$];
  int                exp_order[$];

  function automatic logic [OW-1:0] expv();
    return {e_gnt, e_valid, e_rdata, e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata,
            CW'(q.size()), e_err};
  endfunction

  task automatic model_reset();
`ifdef MEM_ARB_DMA_PRIO_EN
    m_ptr = 1;
`else
    m_ptr = 0;
`endif
    q.delete();
    e_gnt = '0; e_valid = '0; e_rdata = '0; e_mem_req = 1'b0; e_mem_we = 1'b0;
    e_mem_addr = '0; e_mem_wdata = '0; e_err = 1'b0;
  endtask

  // Predict the next output state from current inputs, then advance one clock.
  task automatic cycle();
    int sz, w, p, h;
    bit popv, room;
    logic [NPORTS-1:0] el;
    sz   = q.size();
    popv = mem_valid && (sz > 0);
    room = (sz - (popv ? 1 : 0)) < DEPTH;
    for (int i = 0; i < NPORTS; i++) el[i] = req[i] && !e_gnt[i] && (we[i] || room);
    w = -1;
`ifdef MEM_ARB_DMA_PRIO_EN
    if (el[0]) w = 0;
    else for (int k = 0; k < NPORTS - 1; k++) begin
      p = 1 + ((m_ptr - 1 + k) % (NPORTS - 1));
      if (w < 0 && el[p]) w = p;
    end
    if (w > 0) m_ptr = (w == NPORTS - 1) ? 1 : w + 1;
`else
    for (int k = 0; k < NPORTS; k++) begin
      p = (m_ptr + k) % NPORTS;
      if (w < 0 && el[p]) w = p;
    end
    if (w >= 0) m_ptr = (w + 1) % NPORTS;
`endif
    e_valid = '0;
    if (popv) begin
      h = q.pop_front();
      e_valid[h] = 1'b1;
      e_rdata = mem_rdata;
    end
    if (mem_valid && sz == 0) e_err = 1'b1;
    e_gnt = '0;
    e_mem_req = 1'b0;
    if (w >= 0) begin
      e_gnt[w]    = 1'b1;
      e_mem_req   = 1'b1;
      e_mem_we    = we[w];
      e_mem_addr  = addr[w*AW +: AW];
      e_mem_wdata = wdata[w*DW +: DW];
      if (!we[w]) q.push_back(w);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== {OW{1'b0}}) begin
      n_fail++; $display("FAIL reset_async got=%h exp=0", obs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, expv());
    end
  endtask

  task automatic test_fill_reads();
    bit ok;
    for (int i = 0; i < NPORTS; i++) set_port(i, AW'(64'h1000 + i*16), DW'($urandom));
    req = 3'b111; we = 3'b000;
    got_order.delete();
    for (int c = 0; c < 8; c++) begin
      cycle();
      for (int i = 0; i < NPORTS; i++) if (gnt[i]) got_order.push_back(i);
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL fill_model cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
`ifdef MEM_ARB_DMA_PRIO_EN
    exp_order = '{0, 1, 0, 2};
`else
    exp_order = '{0, 1, 2, 0};
`endif
    ok = (got_order.size() == exp_order.size());
    for (int i = 0; i < got_order.size(); i++) if (ok && got_order[i] != exp_order[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL fill_order got=%p exp=%p", got_order, exp_order);
    end
    n_checks++;
    if (outstanding !== 3'd4) begin
      n_fail++; $display("FAIL fill_outstanding got=%0d exp=4", outstanding);
    end
  endtask

  task automatic test_response_full();
    mem_valid = 1'b1;
    mem_rdata = 64'h00000000000000A5;
    cycle();
    mem_valid = 1'b0;
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL resp_model cyc=%0d got=%h exp=%h", cyc, obs, expv());
    end
    n_checks++;
    if (valid !== 3'b001 || rdata !== 64'h00000000000000A5 || outstanding !== 3'd4 ||
        $countones(gnt) != 1) begin
      n_fail++; $display("FAIL resp_full valid=%b rdata=%h out=%0d gnt=%b exp valid=001 rdata=a5 out=4 one gnt",
                         valid, rdata, outstanding, gnt);
    end
    req = 3'b000;
    cycle();
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL resp_idle cyc=%0d got=%h exp=%h", cyc, obs, expv());
    end
  endtask

  task automatic test_write_full();
    set_port(1, 64'h40, 64'h1234);
    req = 3'b010; we = 3'b010;
    cycle();
    req = 3'b000; we = 3'b000;
    n_checks++;
    if (gnt !== 3'b010 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h40 ||
        mem_wdata !== 64'h1234 || outstanding !== 3'd4) begin
      n_fail++; $display("FAIL write_full gnt=%b req=%b we=%b addr=%h wdata=%h out=%0d exp 010/1/1/40/1234/4",
                         gnt, mem_req, mem_we, mem_addr, mem_wdata, outstanding);
    end
    cycle();
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL write_idle cyc=%0d got=%h exp=%h", cyc, obs, expv());
    end
  endtask

  task automatic test_drain_unexpected();
    for (int i = 0; i < DEPTH; i++) begin
      mem_valid = 1'b1;
      mem_rdata = {$urandom, $urandom};
      cycle();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
    mem_valid = 1'b1;
    cycle();
    mem_valid = 1'b0;
    n_checks++;
    if (valid !== 3'b000 || err_unexp !== 1'b1) begin
      n_fail++; $display("FAIL unexp_flag valid=%b err=%b exp valid=000 err=1", valid, err_unexp);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (err_unexp !== 1'b1 || obs !== expv()) begin
        n_fail++; $display("FAIL unexp_sticky cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b100; we = 3'b000; cycle();
    req = 3'b001; cycle();
    req = 3'b010; cycle();
    req = 3'b000;
    n_checks++;
    if (outstanding !== 3'd3 || obs !== expv()) begin
      n_fail++; $display("FAIL mid_three cyc=%0d got=%h exp=%h", cyc, obs, expv());
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs !== {OW{1'b0}}) begin
      n_fail++; $display("FAIL mid_reset got=%h exp=0", obs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_valid = 1'b1;
    cycle();
    mem_valid = 1'b0;
    n_checks++;
    if (err_unexp !== 1'b1 || valid !== 3'b000) begin
      n_fail++; $display("FAIL mid_stale err=%b valid=%b exp err=1 valid=000", err_unexp, valid);
    end
    req = 3'b100;
    cycle();
    req = 3'b000;
    n_checks++;
    if (gnt !== 3'b100 || mem_req !== 1'b1 || outstanding !== 3'd1) begin
      n_fail++; $display("FAIL mid_regrant gnt=%b req=%b out=%0d exp 100/1/1", gnt, mem_req, outstanding);
    end
  endtask

  task automatic test_write_rotation();
    bit ok;
    do_reset();
    req = 3'b111; we = 3'b111;
    got_order.delete();
    for (int c = 0; c < 6; c++) begin
      cycle();
      for (int i = 0; i < NPORTS; i++) if (gnt[i]) got_order.push_back(i);
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL rot_model cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
    req = 3'b000; we = 3'b000;
`ifdef MEM_ARB_DMA_PRIO_EN
    exp_order = '{0, 1, 0, 2, 0, 1};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    ok = (got_order.size() == exp_order.size());
    for (int i = 0; i < got_order.size(); i++) if (ok && got_order[i] != exp_order[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rot_order got=%p exp=%p", got_order, exp_order);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req       = NPORTS'($urandom);
      we        = NPORTS'($urandom);
      for (int i = 0; i < NPORTS; i++) set_port(i, {$urandom, $urandom}, {$urandom, $urandom});
      mem_valid = ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom};
      cycle();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv());
      end
    end
    req = '0; we = '0; mem_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_reads();
    test_response_full();
    test_write_full();
    test_drain_unexpected();
    test_reset_mid();
    test_write_rotation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
